// File: rtl/morse_char_buffer.sv
// morse_char_buffer
//
// Purpose:
//   Turns single-cycle Morse symbol/gap events from the timing classifier
//   into 6-bit character codes, and keeps the eight most recent characters
//   in a shift-register display buffer that feeds the seven-segment scan
//   driver directly (d0 = rightmost, newest digit).
//
// Code map: digits 0-9 -> 6'h00-6'h09, letters A-Z -> 6'h0A-6'h23,
//           blank -> BLANK_CODE, undecodable pattern -> ERR_CODE.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-high reset, clears all state
//   sym_valid    one-cycle pulse, one Morse symbol completed
//   sym_is_dash  qualifies sym_valid: 1 = dash, 0 = dot
//   char_end     one-cycle pulse, letter gap detected
//   word_end     one-cycle pulse, word gap detected
//   clear        one-cycle pulse, empty the buffer and pending symbols
//   backspace    one-cycle pulse, delete the newest character
//   d0..d7       display slots, d0 is newest
//   char_valid   one-cycle pulse when a character is committed
//   char_code    committed code, valid while char_valid = 1
//   sym_count    symbols pending in the current character (0-5)
//
// Configuration macro: MORSE_BACKSPACE_EN
//   Defined   : backspace removes the newest character and drops any
//               pending symbols.
//   Undefined : the backspace port exists but is ignored.

module morse_char_buffer #(
    parameter logic [5:0] BLANK_CODE = 6'h3F,
    parameter logic [5:0] ERR_CODE   = 6'h3E
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_valid,
    input  logic       sym_is_dash,
    input  logic       char_end,
    input  logic       word_end,
    input  logic       clear,
    input  logic       backspace,
    output logic [5:0] d0,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic       char_valid,
    output logic [5:0] char_code,
    output logic [2:0] sym_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OVERRUN
    } state_t;

    state_t     state;
    logic [4:0] pattern;
    logic [5:0] slot [8];

    logic [4:0] app_pattern;
    logic [2:0] app_count;
    logic       app_overrun;
    logic       pending;
    logic [5:0] commit_code;

`ifndef MORSE_BACKSPACE_EN
    // The name keeps lint quiet about the intentionally unused port.
    logic unused_backspace;
    assign unused_backspace = backspace;
`endif

    // Pattern is shifted in from the LSB, so for a character of length L
    // the bits pattern[L-1:0] read like the written Morse string (first
    // symbol leftmost) and the bits above L stay zero. The decode key is
    // therefore {length, pattern}. Overrun characters always decode to ERR.
    function automatic logic [5:0] decode(input logic [2:0] len,
                                          input logic [4:0] pat,
                                          input logic       ovr);
        logic [5:0] code;
        code = ERR_CODE;
        if (!ovr) begin
            case ({len, pat})
                8'b001_00000: code = 6'h0E; // E
                8'b001_00001: code = 6'h1D; // T
                8'b010_00000: code = 6'h12; // I
                8'b010_00001: code = 6'h0A; // A
                8'b010_00010: code = 6'h17; // N
                8'b010_00011: code = 6'h16; // M
                8'b011_00000: code = 6'h1C; // S
                8'b011_00001: code = 6'h1E; // U
                8'b011_00010: code = 6'h1B; // R
                8'b011_00011: code = 6'h20; // W
                8'b011_00100: code = 6'h0D; // D
                8'b011_00101: code = 6'h14; // K
                8'b011_00110: code = 6'h10; // G
                8'b011_00111: code = 6'h18; // O
                8'b100_00000: code = 6'h11; // H
                8'b100_00001: code = 6'h1F; // V
                8'b100_00010: code = 6'h0F; // F
                8'b100_00100: code = 6'h15; // L
                8'b100_00110: code = 6'h19; // P
                8'b100_00111: code = 6'h13; // J
                8'b100_01000: code = 6'h0B; // B
                8'b100_01001: code = 6'h21; // X
                8'b100_01010: code = 6'h0C; // C
                8'b100_01011: code = 6'h22; // Y
                8'b100_01100: code = 6'h23; // Z
                8'b100_01101: code = 6'h1A; // Q
                8'b101_01111: code = 6'h01;
                8'b101_00111: code = 6'h02;
                8'b101_00011: code = 6'h03;
                8'b101_00001: code = 6'h04;
                8'b101_00000: code = 6'h05;
                8'b101_10000: code = 6'h06;
                8'b101_11000: code = 6'h07;
                8'b101_11100: code = 6'h08;
                8'b101_11110: code = 6'h09;
                8'b101_11111: code = 6'h00;
                default:      code = ERR_CODE;
            endcase
        end
        return code;
    endfunction

    // Pattern as it looks once this cycle's symbol (if any) is appended.
    // A symbol arriving together with a gap is decoded in the same cycle,
    // so commit decodes this view rather than the stored pattern.
    always_comb begin
        app_pattern = pattern;
        app_count   = sym_count;
        app_overrun = (state == OVERRUN);
        if (sym_valid) begin
            if (state == OVERRUN || sym_count == 3'd5) begin
                app_overrun = 1'b1;
            end else begin
                app_pattern = {pattern[3:0], sym_is_dash};
                app_count   = sym_count + 3'd1;
            end
        end
        pending     = (state != IDLE) || sym_valid;
        commit_code = decode(app_count, app_pattern, app_overrun);
    end

    // Main sequencer. Event priority: clear, then backspace, then a gap
    // that commits or inserts a blank, then plain symbol accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pattern    <= '0;
            sym_count  <= '0;
            char_valid <= 1'b0;
            char_code  <= '0;
            for (int i = 0; i < 8; i++) slot[i] <= BLANK_CODE;
        end else begin
            char_valid <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                pattern   <= '0;
                sym_count <= '0;
                char_code <= '0;
                for (int i = 0; i < 8; i++) slot[i] <= BLANK_CODE;
            end
`ifdef MORSE_BACKSPACE_EN
            // Shifting an all-blank buffer right reproduces it, so no
            // special case is needed for an empty display.
            else if (backspace) begin
                state     <= IDLE;
                pattern   <= '0;
                sym_count <= '0;
                for (int i = 0; i < 7; i++) slot[i] <= slot[i+1];
                slot[7] <= BLANK_CODE;
            end
`endif
            else if ((char_end || word_end) && pending) begin
                state      <= IDLE;
                pattern    <= '0;
                sym_count  <= '0;
                char_valid <= 1'b1;
                char_code  <= commit_code;
                if (word_end) begin
                    // Character and trailing blank land in one cycle.
                    for (int i = 2; i < 8; i++) slot[i] <= slot[i-2];
                    slot[1] <= commit_code;
                    slot[0] <= BLANK_CODE;
                end else begin
                    for (int i = 1; i < 8; i++) slot[i] <= slot[i-1];
                    slot[0] <= commit_code;
                end
            end else if (word_end) begin
                // Idle word gap: one blank separator, never a run of them.
                if (slot[0] != BLANK_CODE) begin
                    for (int i = 1; i < 8; i++) slot[i] <= slot[i-1];
                    slot[0] <= BLANK_CODE;
                end
            end else if (sym_valid) begin
                pattern   <= app_pattern;
                sym_count <= app_count;
                state     <= app_overrun ? OVERRUN : ACCUM;
            end
        end
    end

    assign d0 = slot[0];
    assign d1 = slot[1];
    assign d2 = slot[2];
    assign d3 = slot[3];
    assign d4 = slot[4];
    assign d5 = slot[5];
    assign d6 = slot[6];
    assign d7 = slot[7];

endmodule

// File: tb/tb_morse_char_buffer.sv
// tb_morse_char_buffer
//
// Purpose:
//   Self-checking bench for morse_char_buffer. Stimulus tasks push the
//   expected committed codes into a queue and update a small model of the
//   display slots; a negedge monitor pops the queue whenever char_valid is
//   seen. Backspace expectations follow MORSE_BACKSPACE_EN.

module tb_morse_char_buffer;

    localparam logic [5:0] BL = 6'h3F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sym_valid = 1'b0;
    logic       sym_is_dash = 1'b0;
    logic       char_end = 1'b0;
    logic       word_end = 1'b0;
    logic       clear = 1'b0;
    logic       backspace = 1'b0;
    logic [5:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       char_valid;
    logic [5:0] char_code;
    logic [2:0] sym_count;

    logic [5:0] dut_slot [8];
    logic [5:0] model [8];
    logic [5:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    morse_char_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym_is_dash(sym_is_dash),
        .char_end   (char_end),
        .word_end   (word_end),
        .clear      (clear),
        .backspace  (backspace),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .d4         (d4),
        .d5         (d5),
        .d6         (d6),
        .d7         (d7),
        .char_valid (char_valid),
        .char_code  (char_code),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    assign dut_slot[0] = d0;
    assign dut_slot[1] = d1;
    assign dut_slot[2] = d2;
    assign dut_slot[3] = d3;
    assign dut_slot[4] = d4;
    assign dut_slot[5] = d5;
    assign dut_slot[6] = d6;
    assign dut_slot[7] = d7;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Each commit pulse must match the oldest queued expectation; a pulse
    // with nothing queued is itself an error.
    always @(negedge clk) begin
        if (!reset && char_valid === 1'b1) begin
            if (exp_q.size() == 0)
                checkOutput("spurious_char_valid", 1, 0);
            else
                checkOutput("char_code", int'(char_code), int'(exp_q.pop_front()));
        end
    end

    // Drive one cycle's worth of event inputs, then return them to idle.
    task automatic pulse(input logic sv, input logic dash, input logic ce,
                         input logic we, input logic clr, input logic bs);
        sym_valid   = sv;
        sym_is_dash = dash;
        char_end    = ce;
        word_end    = we;
        clear       = clr;
        backspace   = bs;
        @(posedge clk);
        #1;
        sym_valid   = 1'b0;
        sym_is_dash = 1'b0;
        char_end    = 1'b0;
        word_end    = 1'b0;
        clear       = 1'b0;
        backspace   = 1'b0;
    endtask

    task automatic modelShift(input logic [5:0] code);
        for (int i = 7; i >= 1; i--) model[i] = model[i-1];
        model[0] = code;
    endtask

    task automatic modelBlankAll();
        for (int i = 0; i < 8; i++) model[i] = BL;
    endtask

    task automatic sendSyms(input string pat);
        for (int i = 0; i < pat.len(); i++)
            pulse(1'b1, pat[i] == "-", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // endKind: 0 = symbols only, 1 = char_end, 2 = word_end.
    task automatic applyStimulus(input string pat, input int endKind, input logic [5:0] code);
        sendSyms(pat);
        if (endKind == 1) begin
            exp_q.push_back(code);
            modelShift(code);
            pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (endKind == 2) begin
            exp_q.push_back(code);
            modelShift(code);
            modelShift(BL);
            pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic doClear();
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        modelBlankAll();
    endtask

    // Compare all slots with the model and confirm no commit went missing.
    task automatic checkSlots(input string tag);
        @(negedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s_d%0d", tag, i), int'(dut_slot[i]), int'(model[i]));
        checkOutput({tag, "_missing_commits"}, exp_q.size(), 0);
    endtask

    initial begin
        modelBlankAll();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_sym_count", int'(sym_count), 0);
        checkOutput("rst_char_valid", int'(char_valid), 0);
        checkOutput("rst_char_code", int'(char_code), 0);
        checkSlots("rst");

        // 'A'
        applyStimulus(".-", 1, 6'h0A);
        checkSlots("A");

        // S O S
        doClear();
        applyStimulus("...", 1, 6'h1C);
        applyStimulus("---", 1, 6'h18);
        applyStimulus("...", 1, 6'h1C);
        checkSlots("SOS");

        // Digits, word gap, repeated word gap
        doClear();
        applyStimulus(".....", 1, 6'h05);
        checkSlots("dig5");
        applyStimulus("-----", 2, 6'h00);
        checkSlots("dig0_word");
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkSlots("second_word_end");

        // Overrun: six dots hold count at 5 and commit ERR
        doClear();
        sendSyms("......");
        @(negedge clk);
        checkOutput("overrun_sym_count", int'(sym_count), 5);
        applyStimulus("", 1, 6'h3E);
        checkOutput("after_commit_sym_count", int'(sym_count), 0);
        checkSlots("overrun");

        // Lone char_end in IDLE does nothing
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkSlots("lone_char_end");

        // Nine 'E' characters fill the whole buffer
        doClear();
        for (int n = 0; n < 9; n++) applyStimulus(".", 1, 6'h0E);
        checkSlots("nine_E");

        // Symbol and char_end in the same cycle
        doClear();
        sendSyms(".");
        exp_q.push_back(6'h0A);
        modelShift(6'h0A);
        pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkSlots("sym_with_char_end");

        // Back-to-back commits: 'T' then 'E', each in one cycle
        exp_q.push_back(6'h1D);
        modelShift(6'h1D);
        pulse(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(6'h0E);
        modelShift(6'h0E);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkSlots("back_to_back");

        // Idle word_end with a non-blank d0 inserts exactly one blank
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        modelShift(BL);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkSlots("idle_word_end");

        // clear wins over char_end and drops the pending symbol
        applyStimulus("-", 0, 6'h00);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        modelBlankAll();
        checkOutput("clear_sym_count", int'(sym_count), 0);
        checkSlots("clear_with_char_end");

        // Backspace after 'A','B'
        applyStimulus(".-", 1, 6'h0A);
        applyStimulus("-...", 1, 6'h0B);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MORSE_BACKSPACE_EN
        for (int i = 0; i < 7; i++) model[i] = model[i+1];
        model[7] = BL;
`endif
        checkSlots("backspace");

        // Reset in the middle of a character discards the symbols
        sendSyms("..");
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        modelBlankAll();
        @(negedge clk);
        checkOutput("midchar_reset_sym_count", int'(sym_count), 0);
        applyStimulus("-", 1, 6'h1D);
        checkSlots("after_midchar_reset");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_char_buffer.md
# morse_char_buffer

- Converts single-cycle Morse symbol and gap events from the keying front-end into 6-bit character codes.
- Keeps the eight most recent characters in a shift-register display buffer.
- The eight 6-bit slot outputs drive the eight character inputs of the seven-segment scan driver directly; slot d0 is the rightmost, newest digit.
- Sits between the Morse timing classifier (dot/dash/gap detection) and the display path.

## Interface

Parameters:
- BLANK_CODE, 6'h3F, code for an empty or space slot.
- ERR_CODE, 6'h3E, code for an undecodable symbol pattern.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sym_valid  in  1  one-cycle pulse: one Morse symbol completed.
- sym_is_dash  in  1  qualifies sym_valid: 1 = dash, 0 = dot.
- char_end  in  1  one-cycle pulse: letter gap detected.
- word_end  in  1  one-cycle pulse: word gap detected.
- clear  in  1  one-cycle pulse: empty the buffer and the pending symbols.
- backspace  in  1  one-cycle pulse: delete the newest character (see Configuration).
- d0..d7  out  6 each  display slots; d0 is newest.
- char_valid  out  1  one-cycle pulse when a character is committed.
- char_code  out  6  code committed; valid while char_valid = 1.
- sym_count  out  3  symbols pending in the current character (0–5).

## Operation

Character code map:
- Digits 0–9 → 6'h00–6'h09.
- Letters A–Z → 6'h0A–6'h23.
- Blank → BLANK_CODE.
- Any other pattern → ERR_CODE.

Symbol accumulation:
- Pattern register is 5 bits plus a 3-bit length; symbols are stored in arrival order.
- A sixth symbol sets an internal overrun flag. The pattern is frozen and sym_count holds at 5.
- An overrun character commits ERR_CODE.

State machine:
- IDLE (sym_count = 0).
- ACCUM (1–5 symbols pending).
- OVERRUN (more than 5 symbols received).
- Transitions:
  - IDLE → ACCUM on sym_valid.
  - ACCUM → OVERRUN on the 6th sym_valid.
  - ACCUM/OVERRUN → IDLE on char_end or word_end, committing the character.

Commit action:
- Shifts d6..d0 into d7..d1 and loads the new code into d0; d7's old value is discarded.
- Pulses char_valid with char_code equal to the new code.

char_end rules:
- In IDLE it is ignored: no shift and no char_valid.

word_end rules:
- With a character pending: shift by two in one cycle, d1 ← character and d0 ← BLANK_CODE. char_valid pulses once, for the character only.
- In IDLE: shift in one BLANK_CODE, unless d0 already equals BLANK_CODE; then no change. This prevents blank runs. No char_valid for blanks.

Simultaneous events:
- Priority is clear > backspace > commit > symbol.
- sym_valid together with char_end or word_end: the symbol is appended first, then that pattern is decoded and committed in the same cycle.
- clear together with any other event: only clear takes effect.

Reset and clear:
- All slots ← BLANK_CODE, pattern and length ← 0, overrun ← 0, state ← IDLE, char_valid ← 0, char_code ← 0.
- reset asserted mid-character discards the pending symbols immediately.

## Timing

- All outputs are registered.
- Event at edge n → d0..d7, char_valid, char_code and sym_count updated after edge n; visible in cycle n+1.
- char_valid is high for exactly one cycle per commit.
- No backpressure: one event per cycle is accepted, and consecutive-cycle commits are legal.
- Inputs are assumed synchronous to clk; no synchronizers inside.

## Configuration

Macro: MORSE_BACKSPACE_EN.
- Defined:
  - backspace shifts d7..d1 into d6..d0 and loads BLANK_CODE into d7.
  - Any pending symbols are also discarded and the state returns to IDLE.
  - Backspace on a buffer whose slots are all BLANK_CODE leaves the slots unchanged.
- Undefined:
  - The backspace port exists but is ignored; no backspace logic is synthesized.

## Test plan

- After reset: d0..d7 = 6'h3F, sym_count = 0, char_valid = 0. Then dot, dash, char_end → d0 = 6'h0A ('A'), char_valid for 1 cycle with char_code = 6'h0A.
- S, O, S (dot×3, char_end, dash×3, char_end, dot×3, char_end) → d2 = 6'h1C, d1 = 6'h18, d0 = 6'h1C, d3..d7 = 6'h3F.
- Digit patterns:
  - dot×5 then char_end → d0 = 6'h05.
  - dash×5 then word_end → d1 = 6'h00, d0 = 6'h3F.
  - A second word_end leaves the slots unchanged.
- Error handling: dot×6 then char_end → d0 = 6'h3E with sym_count = 5 before the commit. A lone char_end in IDLE produces no shift.
- Edge cases:
  - Nine committed 'E' characters (dot, char_end) → all slots 6'h0E.
  - sym_valid(dash) in the same cycle as char_end after one dot → d0 = 6'h0A.
  - clear in the same cycle as char_end → all slots 6'h3F, no char_valid.
- Backspace, with MORSE_BACKSPACE_EN defined: buffer ..., 'A', 'B'; backspace → d0 = 6'h0A, d7 = 6'h3F. Without the macro the same stimulus leaves the slots unchanged.
